// File: rtl/inst_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_unit
// Purpose  : Instruction fetch stage. Holds the PC, selects the next PC
//            (sequential / branch / jump / register-jump), reads a
//            word-addressed instruction store with a configurable read
//            latency and presents the result to decode over a valid/ready
//            handshake. Supports redirect/flush, a program-load write port
//            and an out-of-range fetch fault flag.
// Ports    : clk, rst_n              clock, async active-low reset
//            i_pc_sel/i_imm16/i_target26/i_jr_addr  next-PC controls
//            i_redirect_valid/i_redirect_addr       flush + restart
//            i_inst_ready, o_inst_valid, o_inst, o_pc, o_fetch_fault
//            i_prog_we/i_prog_addr/i_prog_wdata     program-load port
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch_unit #(
  parameter int                ADDR_W      = 32,
  parameter int                MEM_DEPTH   = 256,
  parameter int                MEM_LATENCY = 1,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        i_pc_sel,
  input  logic [15:0]       i_imm16,
  input  logic [25:0]       i_target26,
  input  logic [ADDR_W-1:0] i_jr_addr,
  input  logic              i_redirect_valid,
  input  logic [ADDR_W-1:0] i_redirect_addr,
  input  logic              i_inst_ready,
  output logic              o_inst_valid,
  output logic [31:0]       o_inst,
  output logic [ADDR_W-1:0] o_pc,
  output logic              o_fetch_fault,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [31:0]       i_prog_wdata
);

  localparam int                IDX_W       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-3:0] c_mem_depth = (ADDR_W-2)'(MEM_DEPTH);
  localparam logic [3:0]        c_lat_last  = 4'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] c_reset_pc  = {RESET_PC[ADDR_W-1:2], 2'b00};

  typedef enum logic [0:0] {
    S_FETCH = 1'b0,
    S_VALID = 1'b1
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_inst;
  logic              r_valid;
  logic              r_fault;

  logic [31:0]       r_mem [MEM_DEPTH];

  logic              w_fetch_oor;
  logic              w_prog_oor;
  logic [ADDR_W-1:0] w_p4;
  logic [ADDR_W-1:0] w_br;
  logic [ADDR_W-1:0] w_jmp;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_unused;

  // Range checks are done on the full word index so aliasing into the
  // store through truncated upper address bits is impossible.
  assign w_fetch_oor = (r_pc[ADDR_W-1:2] >= c_mem_depth);
  assign w_prog_oor  = (i_prog_addr[ADDR_W-1:2] >= c_mem_depth);

  assign w_p4 = r_pc + ADDR_W'(4);
  assign w_br = w_p4 + {{(ADDR_W-18){i_imm16[15]}}, i_imm16, 2'b00};

  if (ADDR_W > 28) begin : g_jmp_hi
    assign w_jmp = {w_p4[ADDR_W-1:28], i_target26, 2'b00};
  end else begin : g_jmp_lo
    assign w_jmp = {i_target26, 2'b00};
  end

  always_comb begin
    w_next_pc = w_p4;
    case (i_pc_sel)
      2'b00:   w_next_pc = w_p4;
      2'b01:   w_next_pc = w_br;
      2'b10:   w_next_pc = w_jmp;
      default: w_next_pc = {i_jr_addr[ADDR_W-1:2], 2'b00};
    endcase
  end

  // Byte-lane bits of the incoming addresses are ignored by design.
  assign w_unused = ^{i_prog_addr[1:0], i_jr_addr[1:0], i_redirect_addr[1:0]};

  // Instruction store: not reset, so a program survives rst_n pulses.
  always_ff @(posedge clk) begin
    if (i_prog_we && !w_prog_oor) begin
      r_mem[i_prog_addr[IDX_W+1:2]] <= i_prog_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_pc    <= c_reset_pc;
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
    end else if (i_redirect_valid) begin
      // Redirect wins over any handshake and drops the in-flight fetch.
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_pc    <= {i_redirect_addr[ADDR_W-1:2], 2'b00};
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (r_cnt == c_lat_last) begin
            // Non-blocking read: a same-edge program write is not seen here.
            r_inst  <= w_fetch_oor ? 32'h0 : r_mem[r_pc[IDX_W+1:2]];
            r_fault <= w_fetch_oor;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_VALID;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        default: begin
          if (i_inst_ready) begin
            r_pc    <= w_next_pc;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
      endcase
    end
  end

  assign o_inst_valid  = r_valid;
  assign o_inst        = r_inst;
  assign o_pc          = r_pc;
  assign o_fetch_fault = r_fault;

endmodule
`default_nettype wire
